// File: rtl/c1541_gcr_stream.sv
// Serialises a GCR track buffer at the 1541 zone bit rate. In read mode it frames bytes
// after SYNC marks; in write mode it stores drive data into the buffer at each byte boundary.
module c1541_gcr_stream (
    input  logic        clk32,
    input  logic        reset,
    input  logic        mtr,
    input  logic [1:0]  freq,
    input  logic        mode,
    input  logic [7:0]  dout,
    output logic [7:0]  din,
    output logic        sync_n,
    output logic        byte_n,
    input  logic [12:0] track_len,
    output logic [12:0] buf_addr,
    input  logic [7:0]  buf_rd_data,
    output logic [7:0]  buf_wr_data,
    output logic        buf_we
);
    logic        active;
    logic [6:0]  div_cnt;
    logic        bit_tick;
    logic [12:0] ptr;
    logic [2:0]  bidx;
    logic        adv_pend;
    logic [9:0]  hist;
    logic [7:0]  dsh;
    logic [2:0]  dcnt;
    logic [4:0]  pcnt;
    logic        mode_q;
    logic        we_q;
    logic        cur_bit;
    logic        boundary;
    logic        mode_chg;
    logic [9:0]  hist_nx;
    logic [7:0]  dsh_nx;
    logic [13:0] ptr_inc;

    // 8*(16-f)-1 == {15-f, 3'b111}, and 15-f == {2'b11, ~f}
    function automatic logic [6:0] reload(input logic [1:0] f);
        return {2'b11, ~f, 3'b111};
    endfunction

    assign active   = mtr && (track_len != 13'd0);
    assign bit_tick = active && (div_cnt == 7'd0);
    // buf_addr sits on ptr for a whole byte, so read data is long settled at each tick
    assign cur_bit  = buf_rd_data[3'd7 - bidx];
    assign boundary = bit_tick && (bidx == 3'd7);
    assign mode_chg = (mode != mode_q);
    assign hist_nx  = {hist[8:0], cur_bit};
    assign dsh_nx   = {dsh[6:0], cur_bit};
    assign ptr_inc  = {1'b0, ptr} + 14'd1;

    assign buf_addr = ptr;
    assign sync_n   = !(active && mode && (hist == 10'h3FF));
    assign byte_n   = !(active && !mode_chg && (pcnt != 5'd0));
    assign buf_we   = we_q && active && !mode && !reset;

    always_ff @(posedge clk32) begin
        if (reset) begin
            div_cnt     <= reload(freq);
            ptr         <= 13'd0;
            bidx        <= 3'd0;
            adv_pend    <= 1'b0;
            hist        <= 10'd0;
            dsh         <= 8'd0;
            dcnt        <= 3'd0;
            pcnt        <= 5'd0;
            din         <= 8'h00;
            mode_q      <= mode;
            we_q        <= 1'b0;
            buf_wr_data <= 8'h00;
        end else begin
            we_q   <= 1'b0;
            mode_q <= mode;
            if (active)
                div_cnt <= (div_cnt == 7'd0) ? reload(freq) : div_cnt - 7'd1;
            if (pcnt != 5'd0)
                pcnt <= pcnt - 5'd1;

            // ptr moves one cycle after the boundary so a write can still target the byte just passed
            if (adv_pend) begin
                adv_pend <= 1'b0;
                ptr      <= (ptr_inc >= {1'b0, track_len}) ? 13'd0 : ptr_inc[12:0];
            end
            if (bit_tick) begin
                bidx <= bidx + 3'd1;
                if (boundary)
                    adv_pend <= 1'b1;
            end

            if (mode_chg) begin
                hist <= 10'd0;
                dcnt <= 3'd0;
                pcnt <= 5'd0;
            end else if (bit_tick && mode) begin
                hist <= hist_nx;
                dsh  <= dsh_nx;
                // framing restarts on SYNC, independent of buffer byte alignment
                if (hist_nx == 10'h3FF) begin
                    dcnt <= 3'd0;
                end else if (dcnt == 3'd7) begin
                    din  <= dsh_nx;
                    dcnt <= 3'd0;
                    pcnt <= 5'd16;
                end else begin
                    dcnt <= dcnt + 3'd1;
                end
            end

            if (boundary && !mode) begin
                we_q        <= 1'b1;
                buf_wr_data <= dout;
                pcnt        <= 5'd16;
            end
        end
    end
endmodule

// File: doc/c1541_gcr_stream.md
C1541_GCR_STREAM -- requirements
Module: c1541_gcr_stream

Interface
REQ-001 SHALL have port clk32  in  1  system clock (32 MHz); all logic on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port mtr  in  1  spindle motor on (1) / off (0), from drive logic.
REQ-004 SHALL have port freq  in  2  speed zone, 0 slowest .. 3 fastest.
REQ-005 SHALL have port mode  in  1  1=read, 0=write.
REQ-006 SHALL have port dout  in  8  disk write data from drive logic.
REQ-007 SHALL have port din  out  8  disk read data to drive logic.
REQ-008 SHALL have port sync_n  out  1  low while a SYNC field is being read.
REQ-009 SHALL have port byte_n  out  1  byte-ready strobe, active low.
REQ-010 SHALL have port track_len  in  13  number of valid GCR bytes in the track buffer, 0..8191.
REQ-011 SHALL have port buf_addr  out  13  track buffer byte address.
REQ-012 SHALL have port buf_rd_data  in  8  track buffer read data, valid 1 cycle after buf_addr.
REQ-013 SHALL have port buf_wr_data  out  8  track buffer write data.
REQ-014 SHALL have port buf_we  out  1  track buffer write enable, 1-cycle pulse.

Function
REQ-015 SHALL generate bit_tick from a down-counter reloaded with 8*(16-freq)-1 (127/119/111/103); freq is sampled only at reload.
REQ-016 SHALL hold the divider, suppress bit_tick, force sync_n=1 and byte_n=1 while mtr=0 or track_len=0.
REQ-017 SHALL keep a buffer pointer ptr (13 bits) and a buffer bit index 0..7, serialising buffer bytes MSB first, one bit per bit_tick.
REQ-018 SHALL, on the bit_tick that consumes bit 0, advance ptr to ptr+1, or to 0 if ptr+1 >= track_len (wrap), and SHALL load the next byte before the next bit_tick.
REQ-019 SHALL wrap ptr to 0 on the next byte boundary if track_len shrinks below ptr+1.
REQ-020 SHALL drive buf_addr = ptr at all times.
REQ-021 Read mode: each bit_tick SHALL shift the bit into a 10-bit history register and an 8-bit data shifter.
REQ-022 Read mode: sync_n SHALL be 0 whenever the last 10 bits are all 1; while sync_n=0 the decoder bit count SHALL be held at 0 and byte_n SHALL stay 1.
REQ-023 Read mode: when the decoder bit count reaches 8 outside SYNC, din SHALL load the data shifter in the same cycle, the count SHALL return to 0, and byte_n SHALL go low for exactly 16 clk32 cycles.
REQ-024 The decoder bit count SHALL be independent of the buffer bit index, so that byte framing follows SYNC, not buffer alignment.
REQ-025 Write mode: sync_n SHALL be 1.
REQ-026 Write mode: at each buffer byte boundary (bit 0 consumed), the block SHALL assert buf_we for 1 cycle with buf_wr_data = dout sampled that cycle and buf_addr = the byte just passed, before ptr advances; byte_n SHALL pulse low for 16 cycles starting the same cycle.
REQ-027 Write mode: din SHALL hold its last value.
REQ-028 A change of mode SHALL clear the decoder bit count and history register, terminate any byte_n pulse (byte_n=1), and leave ptr and the buffer bit index unchanged.
REQ-029 A byte_n pulse in progress SHALL restart its 16-cycle length if a new byte completes before it ends.
REQ-030 buf_we SHALL never assert in read mode, while mtr=0, or while track_len=0.

Reset
REQ-031 On reset: din=8'h00, sync_n=1, byte_n=1, buf_we=0, buf_wr_data=8'h00, ptr=0, buffer bit index=0, decoder count=0, history=0, divider reloaded from current freq.
REQ-032 Reset asserted mid-byte or mid-pulse SHALL take effect on the next clk32 edge, with no buffer write in that cycle.

Verification
REQ-033 mtr=1, freq=3, then freq=0 -> bit_tick spacing 104 then 128 cycles; mtr=0 -> ptr and outputs frozen, sync_n=byte_n=1.
REQ-034 Buffer FF,FF,52,54, track_len=4, mode=1 -> sync_n low from the 10th consecutive 1 bit until the first 0; then din=8'h52 with byte_n low 16 cycles, then din=8'h54.
REQ-035 track_len=5 -> buf_addr sequence 0,1,2,3,4,0; wrap exactly at the 5th byte boundary.
REQ-036 mode=0, dout=8'h55 -> at each byte boundary buf_we=1 for 1 cycle, buf_wr_data=8'h55 at the byte address just passed; sync_n stays 1.
REQ-037 Reset mid-byte with byte_n low -> next cycle byte_n=1, buf_addr=0, din=8'h00, no buf_we.
